// File: rtl/prbs7_err_checker_pkg.sv
// Shared definitions for the PRBS7 error checker: FSM encoding and LFSR geometry.
// PRBS7 polynomial x^7 + x^6 + 1, i.e. taps at bit positions 6 and 5.
package prbs7_err_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LFSR_W = 7;
    localparam int TAP_A  = 6;
    localparam int TAP_B  = 5;

endpackage

// File: rtl/prbs7_err_checker_if.sv
// Bundle of the checker's control, serial data and result signals.
// master = harness side driving the stream, slave = checker side.
interface prbs7_err_checker_if #(
    parameter int CNT_W = 8
) ();

    logic             start;
    logic             bit_in;
    logic             bit_vld;
    logic             busy;
    logic             res_vld;
    logic             match;
    logic [CNT_W-1:0] err_cnt;
    logic             sync_lost;
    logic             done;

    modport master (
        output start, bit_in, bit_vld,
        input  busy, res_vld, match, err_cnt, sync_lost, done
    );

    modport slave (
        input  start, bit_in, bit_vld,
        output busy, res_vld, match, err_cnt, sync_lost, done
    );

endinterface

// File: rtl/prbs7_gen.sv
// PRBS7 reference register: shifts in either the received bit (seeding) or its own feedback.
// next_zero flags that the value about to be shifted in would be the all-zero lockup state.
module prbs7_gen
    import prbs7_err_checker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              shift_en,
    input  logic              use_ext,
    input  logic              ext_bit,
    output logic              exp_bit,
    output logic              next_zero
);

    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;
    logic              shift_in;

    assign exp_bit  = lfsr_reg[TAP_A] ^ lfsr_reg[TAP_B];
    assign shift_in = use_ext ? ext_bit : exp_bit;

    // s[0] is always the newest bit; everything else moves one place up.
    assign lfsr_next[0] = shift_in;
    generate
        for (genvar gi = 1; gi < LFSR_W; gi++) begin : g_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    assign next_zero = (lfsr_next == {LFSR_W{1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= {LFSR_W{1'b0}};
        end else if (load) begin
            lfsr_reg <= load_val;
        end else if (shift_en) begin
            lfsr_reg <= lfsr_next;
        end
    end

endmodule

// File: rtl/xnor_gate.sv
// Single two-input XNOR cell used as the bit equality comparator.
module xnor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a ^ b);

endmodule

// File: rtl/prbs7_err_checker.sv
// PRBS7 bit-error checker: seeds a reference from the stream, then compares and counts
// mismatches over WINDOW bits, re-seeding after RESYNC_ERRS consecutive mismatches.
module prbs7_err_checker
    import prbs7_err_checker_pkg::*;
#(
    parameter int WINDOW      = 16,
    parameter int CNT_W       = 8,
    parameter int RESYNC_ERRS = 4
) (
    input  logic               clk,
    input  logic               rst,
    prbs7_err_checker_if.slave bus
);

    localparam int               RUN_W     = $clog2(RESYNC_ERRS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WINDOW - 1);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(RESYNC_ERRS - 1);
    localparam logic [2:0]       SEED_LAST = 3'(LFSR_W - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [2:0]       seed_cnt_reg;
    logic [RUN_W-1:0] run_errs_reg;
    logic             res_vld_reg;
    logic             match_reg;
    logic             sync_lost_reg;
    logic             busy_flag;
    logic             done_flag;

    logic exp_bit;
    logic next_zero;
    logic match_d;
    logic run_accept;
    logic vld_sync;
    logic vld_check;
    logic seed_full;
    logic resync_hit;
    logic window_end;

    assign run_accept = (state_reg == ST_IDLE) && bus.start;
    assign vld_sync   = (state_reg == ST_SYNC) && bus.bit_vld;
    assign vld_check  = (state_reg == ST_CHECK) && bus.bit_vld;
    assign seed_full  = (seed_cnt_reg == SEED_LAST);
    assign resync_hit = vld_check && !match_d && (run_errs_reg == RUN_LAST);
    assign window_end = vld_check && (bit_cnt_reg == LAST_BIT);

    // While seeding the register takes the line; while checking it free-runs on feedback.
    prbs7_gen u_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (run_accept),
        .load_val  ({LFSR_W{1'b0}}),
        .shift_en  (vld_sync || vld_check),
        .use_ext   (state_reg == ST_SYNC),
        .ext_bit   (bus.bit_in),
        .exp_bit   (exp_bit),
        .next_zero (next_zero)
    );

    xnor_gate u_cmp (
        .a (bus.bit_in),
        .b (exp_bit),
        .y (match_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_SYNC;
            ST_SYNC:  if (vld_sync && seed_full && !next_zero) state_next = ST_CHECK;
            // A re-sync on the final window bit takes priority over finishing.
            ST_CHECK: begin
                if (resync_hit) begin
                    state_next = ST_SYNC;
                end else if (window_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_flag = 1'b0;
        done_flag = 1'b0;
        case (state_reg)
            ST_SYNC, ST_CHECK: busy_flag = 1'b1;
            ST_DONE:           done_flag = 1'b1;
            default:           ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            seed_cnt_reg  <= '0;
            run_errs_reg  <= '0;
            res_vld_reg   <= 1'b0;
            match_reg     <= 1'b0;
            sync_lost_reg <= 1'b0;
        end else begin
            res_vld_reg   <= vld_check;
            sync_lost_reg <= resync_hit;
            if (vld_check) begin
                match_reg <= match_d;
            end

            if (run_accept) begin
                err_cnt_reg  <= '0;
                bit_cnt_reg  <= '0;
                seed_cnt_reg <= '0;
                run_errs_reg <= '0;
            end

            // Seed counter restarts both on a lockup seed and on a good one.
            if (vld_sync) begin
                if (seed_full) begin
                    seed_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                end else begin
                    seed_cnt_reg <= seed_cnt_reg + 3'd1;
                end
            end

            if (vld_check) begin
                bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                if (!match_d) begin
                    if (err_cnt_reg != CNT_MAX) begin
                        err_cnt_reg <= err_cnt_reg + CNT_ONE;
                    end
                    if (resync_hit) begin
                        run_errs_reg <= '0;
                        seed_cnt_reg <= '0;
                    end else begin
                        run_errs_reg <= run_errs_reg + RUN_ONE;
                    end
                end else begin
                    run_errs_reg <= '0;
                end
            end
        end
    end

    assign bus.busy      = busy_flag;
    assign bus.done      = done_flag;
    assign bus.res_vld   = res_vld_reg;
    assign bus.match     = match_reg;
    assign bus.sync_lost = sync_lost_reg;
    assign bus.err_cnt   = err_cnt_reg;

endmodule

// File: doc/prbs7_err_checker.md
Name: prbs7_err_checker

Overview:
- Serial bit-error checker that sits directly downstream of the xnor_gate cell.
- It self-synchronises a PRBS7 reference (x^7+x^6+1) to an incoming serial stream. It then compares each received bit against the expected bit using an XNOR equality check, and counts mismatches over a programmable window.
- Its outputs are a per-bit match flag, an error count, a done pulse and a sync-lost indication, consumed by the gate-level test harness.

Parameters:
- WINDOW, 16: number of valid bits checked per run after sync (1..2^CNT_W-1).
- CNT_W, 8: width of err_cnt and of the internal bit counter.
- RESYNC_ERRS, 4: consecutive mismatches in CHECK that force re-sync (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a run; honoured only in IDLE
- bit_in  input  1  received serial bit
- bit_vld  input  1  bit_in qualifier; bits with bit_vld=0 are ignored
- busy  output  1  high in SYNC or CHECK
- res_vld  output  1  registered; high the cycle after a CHECK-state valid bit
- match  output  1  registered XNOR(bit_in, expected); meaningful when res_vld=1
- err_cnt  output  CNT_W  mismatches in current/last run, saturating
- sync_lost  output  1  one-cycle pulse when RESYNC_ERRS consecutive mismatches occur
- done  output  1  one-cycle pulse when the window completes

Behaviour:
- Reset (async, immediate): state=IDLE, lfsr=0, bit_cnt=0, seed_cnt=0, run_errs=0. All outputs are 0.
- State register s[6:0]: s[0] is the newest bit. Expected bit exp = s[6]^s[5]. Shift is s <= {s[5:0], x}.
- IDLE:
  - start=1 -> SYNC; clear err_cnt, bit_cnt, seed_cnt, run_errs.
  - err_cnt otherwise holds the last result.
- SYNC:
  - Each bit_vld shifts bit_in into s and increments seed_cnt.
  - On the 7th valid bit, evaluate the post-shift seed:
    - all-zero (lockup state) -> stay in SYNC, seed_cnt=0;
    - otherwise -> CHECK, bit_cnt=0.
  - No res_vld in SYNC.
- CHECK, each bit_vld:
  - match_d = ~(bit_in ^ exp).
  - s shifts in exp, not bit_in (free-running reference).
  - bit_cnt++.
  - On mismatch: err_cnt++ (saturates at 2^CNT_W-1, no wrap) and run_errs++. On match: run_errs=0.
  - res_vld=1 and match=match_d on the next edge.
- Re-sync: if run_errs reaches RESYNC_ERRS on a valid bit, then:
  - sync_lost pulses one cycle and state -> SYNC;
  - seed_cnt=0, run_errs=0;
  - err_cnt retained (includes those errors);
  - bit_cnt restarts at 0 on re-entry to CHECK.
- Window end: the valid bit with bit_cnt==WINDOW-1 moves to DONE.
  - If that bit also triggers re-sync, re-sync wins.
- DONE: done=1 for exactly one cycle, then -> IDLE. busy=0 in DONE.
- start outside IDLE is ignored. start in the same cycle as the done pulse is ignored.
- bit_vld gaps: no state change; res_vld=0 in the following cycle.
- Latency: bit_vld edge -> res_vld/match one clock later. done asserts the clock after the last window bit is sampled.
- Reset mid-run: abort to IDLE immediately. No done or sync_lost pulse is produced.

Decomposition:
- Shared package/header (prbs_pkg): state encodings IDLE=0, SYNC=1, CHECK=2, DONE=3; PRBS7 tap constants 6 and 5; LFSR width 7.
- Natural sub-module prbs7_gen:
  - 7-bit register with load/shift controls (shift-in select: external bit vs. feedback);
  - exp output and an all-zero flag.
- Top level: the FSM and counters, plus the per-bit compare through an xnor_gate instance.

Test Plan:
- Clean PRBS7 from seed 7'h7F, bit_vld always 1, WINDOW=16 -> busy for 23 cycles; 16 res_vld pulses, all match=1; done one cycle after the 23rd bit; err_cnt=0.
- Same stream with bits 3, 9 and 14 of the window inverted -> match=0 on exactly those three results; err_cnt=3; no sync_lost.
- bit_vld toggling 1,0,1,0 over a clean stream -> result identical to the clean case; res_vld never asserted in back-to-back cycles; done after 46 cycles.
- Seven zeros then a valid PRBS -> stays in SYNC through the zeros; locks on the next 7 bits; err_cnt=0.
- Four consecutive inverted bits in CHECK -> sync_lost pulse on the 4th; re-sync on the next 7 bits; err_cnt=4 at done.
- rst asserted mid-CHECK with err_cnt=2 -> all outputs 0 asynchronously; state IDLE; a new start begins a clean run. Also, CNT_W=2 with 5 errors -> err_cnt saturates at 3.
